// File: rtl/serial_parallel_pkg.sv
// serial_parallel_pkg
//   Constants shared by both ends of the parallel/serial link: the K28.5 idle
//   comma, the receiver state encoding and the default lock threshold.
//   The transmitter (parallel_serial) uses COMMA_K285 as its idle fill.
package serial_parallel_pkg;

  localparam logic [7:0] COMMA_K285 = 8'hBC;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam int LOCK_COUNT_DEFAULT = 4;

endpackage

// File: rtl/serial_parallel_if.sv
// serial_parallel_if
//   Serial input and recovered-byte outputs of the link receiver.
//   master : drives data_in, observes the recovered byte stream
//   slave  : the receiver itself
//   data_in   serial bit, MSB first
//   data_out  last recovered data byte
//   valid_out data_out holds a byte from the current byte slot
//   active    link locked and passing data
interface serial_parallel_if #(parameter int WIDTH = 8);

  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             active;

  modport master (output data_in, input data_out, input valid_out, input active);
  modport slave  (input data_in, output data_out, output valid_out, output active);

endinterface

// File: rtl/serial_parallel_shift_counter.sv
// sp_shift_counter
//   Serial shift register plus mod-WIDTH bit counter for the link receiver.
//   clk_32f   bit clock
//   reset     asynchronous, active-high
//   data_in   serial bit
//   realign   synchronous: restart the byte slot so the next bit is bit 0
//   cand      byte ending with the bit currently on data_in
//   byte_done current bit completes a byte slot
module sp_shift_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  input  logic             realign,
  output logic [WIDTH-1:0] cand,
  output logic             byte_done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  // Only WIDTH-1 history bits are stored; the newest bit comes straight from
  // data_in so cand is available on the edge that samples it.
  logic [WIDTH-2:0] sr;
  logic [BW-1:0]    bit_cnt;

  assign cand      = {sr, data_in};
  assign byte_done = (bit_cnt == LAST_BIT);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      sr <= cand[WIDTH-2:0];
      if (realign || byte_done) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_parallel.sv
// serial_parallel
//   Receive end of the parallel/serial link. Hunts for the idle comma at any
//   bit offset, locks after LOCK_COUNT consecutive aligned commas, then
//   presents each non-comma byte with a valid flag (commas are dropped).
//   clk_32f  bit clock, one serial bit per rising edge
//   reset    asynchronous, active-high
//   bus      serial_parallel_if slave: data_in, data_out, valid_out, active
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_HUNT   | sliding search for the comma at every bit offset
//   ST_SYNC   | byte-aligned, counting consecutive commas toward lock
//   ST_ACTIVE | locked; non-comma bytes are presented on data_out
module serial_parallel
  import serial_parallel_pkg::*;
#(
  parameter int             WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA    = COMMA_K285,
  parameter int             LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
  input  logic            clk_32f,
  input  logic            reset,
  serial_parallel_if.slave bus
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  // comma_cnt value that the next aligned comma turns into a lock
  localparam logic [CW-1:0] LOCK_PREV = CW'(LOCK_COUNT - 1);

  logic [1:0]       state;
  logic [CW-1:0]    comma_cnt;
  logic [WIDTH-1:0] cand;
  logic             byte_done;
  logic             cand_is_comma;
  logic             realign;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             active_q;

  assign cand_is_comma = (cand == COMMA);
  // The comma found while hunting defines the boundary: the next bit is bit 0.
  assign realign       = (state == ST_HUNT) && cand_is_comma;

  sp_shift_counter #(.WIDTH(WIDTH)) u_shift (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (bus.data_in),
    .realign   (realign),
    .cand      (cand),
    .byte_done (byte_done)
  );

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state     <= ST_HUNT;
      comma_cnt <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      case (state)
        ST_HUNT: begin
          if (cand_is_comma) begin
            comma_cnt <= CW'(1);
            if (LOCK_COUNT == 1) begin
              state    <= ST_ACTIVE;
              active_q <= 1'b1;
            end else begin
              state <= ST_SYNC;
            end
          end
        end
        ST_SYNC: begin
          if (byte_done) begin
            if (cand_is_comma) begin
              comma_cnt <= comma_cnt + 1'b1;
              if (comma_cnt == LOCK_PREV) begin
                state    <= ST_ACTIVE;
                active_q <= 1'b1;
              end
            end else begin
              // Alignment was a false positive; resume sliding search.
              state     <= ST_HUNT;
              comma_cnt <= '0;
            end
          end
        end
        ST_ACTIVE: begin
          // No loss-of-sync detection: stays here until reset.
          if (byte_done) begin
            if (cand_is_comma) begin
              valid_q <= 1'b0;
            end else begin
              data_q  <= cand;
              valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_HUNT;
        end
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.active    = active_q;

endmodule
